// File: rtl/phmm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phmm_pkg: shared fp64 operand/result types and issue FSM encoding.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package phmm_pkg;

  localparam int FP64_W        = 64;
  localparam int TAG_W_DEFAULT = 8;

  typedef logic [FP64_W-1:0] fp64_t;

  // Seven transition probabilities, packed highest index first.
  typedef logic [6:0][FP64_W-1:0] transition_probs_t;

  typedef struct packed {
    fp64_t m;
    fp64_t i;
    fp64_t d;
    fp64_t t_a;
    fp64_t t_b;
  } pe_calcs_t;

  typedef logic [TAG_W_DEFAULT-1:0] tag_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ADV  = 2'd2,
    ST_GAP  = 2'd3
  } issue_state_e;

endpackage

`default_nettype wire

// File: rtl/pe_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pe_issue_ctrl: drives one PE through enable/done/advance per cell and |
// | holds its result; define PE_WATCHDOG_EN for the RUN-state watchdog.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pe_issue_ctrl
  import phmm_pkg::*;
#(
  parameter int TAG_W       = 8,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             global_stall,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [447:0]     op_probs,
  input  logic [319:0]     op_vals,
  input  logic [63:0]      op_prior,
  input  logic             op_first,
  output logic             pe_enable,
  output logic             pe_advance,
  output logic             pe_set_tb_special,
  output logic [447:0]     pe_probs,
  output logic [319:0]     pe_vals_in,
  output logic [63:0]      pe_prior,
  output logic [TAG_W-1:0] pe_tag,
  output logic             pe_global_stall,
  input  logic             pe_done,
  input  logic             pe_stall,
  input  logic [319:0]     pe_vals_out,
  input  logic [TAG_W-1:0] pe_tag_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [319:0]     res_vals,
  output logic [TAG_W-1:0] res_tag,
  output logic             wd_err
);

  localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  issue_state_e      state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [TAG_W-1:0]  tag_cnt_q, tag_cnt_d;
  transition_probs_t probs_q, probs_d;
  pe_calcs_t         vals_q, vals_d;
  fp64_t             prior_q, prior_d;
  logic              special_q, special_d;
  logic              res_valid_q, res_valid_d;
  pe_calcs_t         res_vals_q, res_vals_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;

  logic accept;
  logic capture;
  logic slot_free;

  assign accept    = op_valid && op_ready;
  assign capture   = (state_q == ST_ADV) && !global_stall;
  assign slot_free = !res_valid_q || res_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    if (!global_stall) begin
      case (state_q)
        ST_IDLE: if (op_valid) state_d = ST_RUN;
        ST_RUN:  if (pe_done && !pe_stall && slot_free) state_d = ST_ADV;
        ST_ADV: begin
          gap_cnt_d = '0;
          state_d   = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
          else                       gap_cnt_d = gap_cnt_q + 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    op_ready          = 1'b0;
    pe_enable         = 1'b0;
    pe_advance        = 1'b0;
    pe_set_tb_special = 1'b0;
    case (state_q)
      ST_IDLE: op_ready = !global_stall && !reset;
      ST_RUN: begin
        pe_enable         = 1'b1;
        pe_set_tb_special = special_q;
      end
      ST_ADV: begin
        pe_enable  = 1'b1;
        pe_advance = 1'b1;
      end
      default: ;
    endcase
  end

  // special_q survives a stalled first RUN cycle so the PE still sees it once.
  always_comb begin
    tag_cnt_d   = tag_cnt_q;
    probs_d     = probs_q;
    vals_d      = vals_q;
    prior_d     = prior_q;
    special_d   = special_q;
    res_valid_d = res_valid_q;
    res_vals_d  = res_vals_q;
    res_tag_d   = res_tag_q;
    if (accept) begin
      tag_cnt_d = tag_cnt_q + 1'b1;
      probs_d   = op_probs;
      vals_d    = op_vals;
      prior_d   = op_prior;
      special_d = op_first;
    end
    if ((state_q == ST_RUN) && !global_stall) special_d = 1'b0;
    if (capture) begin
      res_valid_d = 1'b1;
      res_vals_d  = pe_vals_out;
      res_tag_d   = pe_tag_out;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_cnt_q   <= '0;
      probs_q     <= '0;
      vals_q      <= '0;
      prior_q     <= '0;
      special_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_vals_q  <= '0;
      res_tag_q   <= '0;
    end else begin
      tag_cnt_q   <= tag_cnt_d;
      probs_q     <= probs_d;
      vals_q      <= vals_d;
      prior_q     <= prior_d;
      special_q   <= special_d;
      res_valid_q <= res_valid_d;
      res_vals_q  <= res_vals_d;
      res_tag_q   <= res_tag_d;
    end
  end

  assign pe_probs        = probs_q;
  assign pe_vals_in      = vals_q;
  assign pe_prior        = prior_q;
  assign pe_tag          = tag_cnt_q;
  assign pe_global_stall = global_stall;
  assign res_valid       = res_valid_q;
  assign res_vals        = res_vals_q;
  assign res_tag         = res_tag_q;

`ifdef PE_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_err_q, wd_err_d;

  // Saturates at the limit; the error is sticky and never forces completion.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_err_d = wd_err_q;
    if (accept) begin
      wd_cnt_d = '0;
    end else if ((state_q == ST_RUN) && !global_stall && !pe_done &&
                 (wd_cnt_q != WD_W'(TIMEOUT_CYC))) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) wd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign wd_err = wd_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign wd_err         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pe_issue_ctrl: directed + random bench with a PE responder model   |
// | and a tag/result scoreboard. Rev 1.0                                  |
// +----------------------------------------------------------------------+
module tb_pe_issue_ctrl;

  localparam int TAG_W   = 8;
  localparam int GAP_CYC = 2;
  localparam int TIMEOUT = 64;

  logic               clock = 1'b0;
  logic               reset, global_stall, op_valid, op_first, res_ready, pe_stall;
  logic [447:0]       op_probs;
  logic [319:0]       op_vals;
  logic [63:0]        op_prior;
  logic               op_ready, pe_enable, pe_advance, pe_set_tb_special, pe_global_stall;
  logic [447:0]       pe_probs;
  logic [319:0]       pe_vals_in, res_vals;
  logic [63:0]        pe_prior;
  logic [TAG_W-1:0]   pe_tag, res_tag;
  logic               res_valid, wd_err;
  logic               pe_done = 1'b0;
  logic [319:0]       pe_vals_out = '0;
  logic [TAG_W-1:0]   pe_tag_out = '0;

  pe_issue_ctrl #(.TAG_W(TAG_W), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .global_stall(global_stall),
    .op_valid(op_valid), .op_ready(op_ready), .op_probs(op_probs), .op_vals(op_vals),
    .op_prior(op_prior), .op_first(op_first),
    .pe_enable(pe_enable), .pe_advance(pe_advance), .pe_set_tb_special(pe_set_tb_special),
    .pe_probs(pe_probs), .pe_vals_in(pe_vals_in), .pe_prior(pe_prior), .pe_tag(pe_tag),
    .pe_global_stall(pe_global_stall), .pe_done(pe_done), .pe_stall(pe_stall),
    .pe_vals_out(pe_vals_out), .pe_tag_out(pe_tag_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_vals(res_vals), .res_tag(res_tag),
    .wd_err(wd_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [319:0]     vals;
  } exp_t;

  exp_t             exp_q[$];
  logic [TAG_W-1:0] m_tag = '0;
  int               errors = 0, checks = 0;
  int               adv_cnt, spec_cnt, res_cnt, low_run, n_gaps, bad_gaps;
  logic [TAG_W-1:0] last_rtag;
  bit               seen_en, last_fop;
  int               pe_lat = 5;
  bit               pe_hang = 1'b0;
  int               pe_cnt = 0;

  // The PE's cell result, as a pure function of the operand bundle.
  function automatic logic [319:0] pe_func(input logic [319:0] v, input logic [63:0] p,
                                           input logic [447:0] pr);
    return {v[255:0], v[319:256]} ^ {5{p}} ^ {pr[447:320], pr[191:0]};
  endfunction

  function automatic logic [447:0] rnd448();
    logic [447:0] r;
    for (int i = 0; i < 14; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // PE responder: raises done after pe_lat enabled cycles, drops it on advance.
  always @(posedge clock) begin
    if (reset) begin
      pe_done <= 1'b0;
      pe_cnt  <= 0;
    end else if (!pe_global_stall) begin
      if (pe_advance) begin
        pe_done <= 1'b0;
        pe_cnt  <= 0;
      end else if (pe_enable && !pe_done) begin
        pe_cnt <= pe_cnt + 1;
        if (!pe_hang && (pe_cnt + 1 >= pe_lat)) begin
          pe_done     <= 1'b1;
          pe_vals_out <= pe_func(pe_vals_in, pe_prior, pe_probs);
          pe_tag_out  <= pe_tag;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [447:0] obs, input logic [447:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update the model after it.
  task automatic tick();
    logic             fo, fr, rs;
    logic [447:0]     cp;
    logic [319:0]     cv, crv;
    logic [63:0]      cpr;
    logic [TAG_W-1:0] crt;
    exp_t             e;
    #1;
    fo = op_valid && op_ready; fr = res_valid && res_ready; rs = reset;
    cp = op_probs; cv = op_vals; cpr = op_prior; crv = res_vals; crt = res_tag;
    @(posedge clock);
    #1;
    last_fop = fo;
    if (rs) begin
      exp_q.delete();
      m_tag   = '0;
      seen_en = 1'b0;
      low_run = 0;
    end else begin
      if (fr) begin
        chk("res_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("res_tag", crt, e.tag);
          chk("res_vals", crv, e.vals);
          res_cnt++;
          last_rtag = crt;
        end
      end
      if (fo) begin
        m_tag  = m_tag + 1'b1;
        e.tag  = m_tag;
        e.vals = pe_func(cv, cpr, cp);
        exp_q.push_back(e);
      end
    end
    if (pe_advance) adv_cnt++;
    if (pe_set_tb_special) spec_cnt++;
    if (pe_enable) begin
      if (seen_en && low_run > 0) begin
        n_gaps++;
        if (low_run != GAP_CYC + 1) bad_gaps++;
      end
      low_run = 0;
      seen_en = 1'b1;
    end else begin
      low_run++;
    end
  endtask

  task automatic send_op(input logic first, input logic [63:0] prior, output int n);
    op_valid = 1'b1; op_first = first; op_prior = prior;
    op_probs = rnd448(); op_vals = rnd320();
    n = 0;
    do begin tick(); n++; end while (!last_fop && n < 200);
    chk("op_accepted", last_fop, 1);
    op_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ctl"}, {op_ready, pe_enable, pe_advance, pe_set_tb_special, res_valid, wd_err}, 0);
    chk({pfx, "_pe_probs"}, pe_probs, 0);
    chk({pfx, "_pe_vals"}, pe_vals_in, 0);
    chk({pfx, "_pe_prior_tag"}, {pe_prior, pe_tag}, 0);
    chk({pfx, "_res"}, {res_vals, res_tag}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int               n, acc, cyc;
    logic [447:0]     hold_vals;
    logic [TAG_W-1:0] t3_tag;
    logic             wd_exp;
    reset = 1'b1; global_stall = 1'b0; op_valid = 1'b0; op_first = 1'b0;
    res_ready = 1'b0; pe_stall = 1'b0; op_probs = '0; op_vals = '0; op_prior = '0;

    // 1: single cell, first-of-column, prior 0.5
    tick(); tick();
    chk_zero("t1_reset");
    reset = 1'b0;
    tick();
    chk("t1_ready_idle", op_ready, 1);
    adv_cnt = 0; spec_cnt = 0; pe_lat = 5;
    send_op(1'b1, 64'h3FE0_0000_0000_0000, n);
    chk("t1_enable_after_accept", pe_enable, 1);
    chk("t1_special", pe_set_tb_special, 1);
    chk("t1_pe_tag", pe_tag, 1);
    chk("t1_pe_prior", pe_prior, 64'h3FE0_0000_0000_0000);
    hold_vals = op_vals;
    chk("t1_pe_vals", pe_vals_in, hold_vals);
    n = 0;
    while (!pe_advance && n < 50) begin tick(); n++; end
    chk("t1_accept_to_adv", n, 6);
    chk("t1_res_empty_in_adv", res_valid, 0);
    tick();
    chk("t1_res_valid", res_valid, 1);
    chk("t1_enable_low_gap", pe_enable, 0);
    chk("t1_res_tag", res_tag, 1);
    chk("t1_special_cycles", spec_cnt, 1);
    chk("t1_adv_pulses", adv_cnt, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t1_res_drained", res_valid, 0);

    // 2: 300 back-to-back cells, tag wrap and gap length
    do_reset();
    res_ready = 1'b1; res_cnt = 0; n_gaps = 0; bad_gaps = 0; acc = 0; cyc = 0;
    op_valid = 1'b1; op_first = 1'($urandom); op_probs = rnd448();
    op_vals = rnd320(); op_prior = {$urandom, $urandom};
    while (acc < 300 && cyc < 5000) begin
      tick(); cyc++;
      if (last_fop) begin
        acc++;
        pe_lat = $urandom_range(1, 6);
        op_first = 1'($urandom); op_probs = rnd448();
        op_vals = rnd320(); op_prior = {$urandom, $urandom};
      end
    end
    op_valid = 1'b0;
    chk("t2_accepted", acc, 300);
    n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 100) begin tick(); n++; end
    chk("t2_results", res_cnt, 300);
    chk("t2_last_tag", last_rtag, 44);
    chk("t2_gap_count", n_gaps, 299);
    chk("t2_bad_gaps", bad_gaps, 0);

    // 3: full result slot blocks the second cell's advance
    res_ready = 1'b0; pe_lat = 3;
    send_op(1'b0, {$urandom, $urandom}, n);
    n = 0;
    while (!res_valid && n < 50) begin tick(); n++; end
    chk("t3_first_result", res_valid, 1);
    t3_tag = exp_q[0].tag;
    send_op(1'b0, {$urandom, $urandom}, n);
    n = 0;
    while (!pe_done && n < 50) begin tick(); n++; end
    chk("t3_done_seen", pe_done, 1);
    adv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_run", {pe_enable, pe_advance, pe_done}, 3'b101);
    end
    chk("t3_no_adv", adv_cnt, 0);
    chk("t3_res_tag_held", res_tag, t3_tag);
    res_ready = 1'b1;
    tick();
    chk("t3_adv_on_release", pe_advance, 1);
    tick();
    chk("t3_second_captured", res_valid, 1);
    tick();
    chk("t3_drained", {res_valid, 32'(exp_q.size())}, 0);

    // 4: global stall in RUN, then in GAP
    pe_lat = 8;
    send_op(1'b0, {$urandom, $urandom}, n);
    tick(); tick();
    global_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_run_frozen", {pe_enable, pe_advance, op_ready, pe_global_stall}, 4'b1001);
      chk("t4_run_tag", pe_tag, m_tag);
    end
    global_stall = 1'b0;
    n = 0;
    while (!pe_advance && n < 50) begin tick(); n++; end
    chk("t4_run_to_adv", n, 7);
    tick();
    global_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_gap_frozen", {pe_enable, op_ready}, 0);
    end
    chk("t4_res_drained_in_stall", {res_valid, 32'(exp_q.size())}, 0);
    global_stall = 1'b0;
    send_op(1'b0, {$urandom, $urandom}, n);
    chk("t4_gap_after_stall", n, 3);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    chk("t4_second_done", exp_q.size(), 0);

    // 5: reset three cycles into RUN
    pe_lat = 10;
    send_op(1'b0, {$urandom, $urandom}, n);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk_zero("t5_reset");
    reset = 1'b0;
    pe_lat = 2;
    send_op(1'b0, {$urandom, $urandom}, n);
    chk("t5_tag_restart", pe_tag, 1);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    chk("t5_done", {res_cnt > 300, 32'(exp_q.size())}, {1'b1, 32'd0});

    // 7: random backpressure, latency and PE stall
    acc = 0; cyc = 0;
    op_valid = 1'b1; op_probs = rnd448(); op_vals = rnd320(); op_prior = {$urandom, $urandom};
    while (acc < 40 && cyc < 3000) begin
      res_ready = 1'($urandom);
      pe_stall  = ($urandom_range(0, 3) == 0);
      tick(); cyc++;
      if (last_fop) begin
        acc++;
        pe_lat = $urandom_range(1, 6);
        op_probs = rnd448(); op_vals = rnd320(); op_prior = {$urandom, $urandom};
      end
    end
    op_valid = 1'b0; res_ready = 1'b1; pe_stall = 1'b0;
    chk("t7_accepted", acc, 40);
    n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 200) begin tick(); n++; end
    chk("t7_drained", {res_valid, 32'(exp_q.size())}, 0);

    // 6: PE never finishes
`ifdef PE_WATCHDOG_EN
    wd_exp = 1'b1;
`else
    wd_exp = 1'b0;
`endif
    pe_hang = 1'b1;
    send_op(1'b0, {$urandom, $urandom}, n);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("t6_wd_before_limit", wd_err, 0);
    tick();
    chk("t6_wd_at_limit", wd_err, wd_exp);
    for (int i = 0; i < 20; i++) tick();
    chk("t6_wd_sticky", {wd_err, pe_enable, pe_advance}, {wd_exp, 2'b10});
    reset = 1'b1;
    tick();
    chk("t6_wd_cleared", wd_err, 0);
    reset = 1'b0; pe_hang = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
